// File: rtl/div_seq.sv
// div_seq - multi-cycle restoring divider (one quotient bit per clock).
//
// Trial subtraction is done by adding the two's complement of the divisor
// magnitude and testing the carry-out. Signed divides work on magnitudes and
// fix the signs afterwards: the quotient truncates toward zero and the
// remainder takes the dividend's sign. Divide-by-zero short-circuits to an
// all-ones quotient with the raw dividend as the remainder.
//
// Ports
//   clock        in   1      rising-edge clock
//   clear        in   1      synchronous active-high reset, priority over start
//   start        in   1      request a divide, sampled only when idle
//   signed_op    in   1      1 = two's-complement divide, 0 = unsigned
//   dividend     in   WIDTH  numerator, captured on an accepted start
//   divisor      in   WIDTH  denominator, captured on an accepted start
//   busy         out  1      operation in flight (RUN/FIX/DONE states)
//   done         out  1      one-cycle pulse, results valid
//   quotient     out  WIDTH  held until the next accepted start completes
//   remainder    out  WIDTH  held until the next accepted start completes
//   div_by_zero  out  1      set with the divide-by-zero result, held likewise
module div_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic             signed_op,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_by_zero
);

   localparam int unsigned CW = $clog2(WIDTH);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] FIX  = 2'd2;
   localparam logic [1:0] DONE = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    count_q, count_d;
   logic [WIDTH:0]   p_q, p_d;        // partial remainder
   logic [WIDTH-1:0] a_q, a_d;        // dividend magnitude shifting into quotient
   logic [WIDTH-1:0] b_q, b_d;        // divisor magnitude
   logic             sq_q, sq_d;
   logic             sr_q, sr_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rem_q, rem_d;
   logic             dbz_q, dbz_d;
   logic             done_q, done_d;

   logic [WIDTH:0]   p_shift;
   logic [WIDTH+1:0] trial;
   logic             carry;
   logic             unused_p_msb;

   // P stays below the divisor after every step, so its top bit is always
   // zero and drops out when shifting.
   assign p_shift      = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
   assign unused_p_msb = p_q[WIDTH];

   // P - B as P + ~B + 1; carry-out set means the subtraction did not borrow.
   assign trial = {1'b0, p_shift} + {1'b0, ~{1'b0, b_q}} + (WIDTH+2)'(1);
   assign carry = trial[WIDTH+1];

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      p_d     = p_q;
      a_d     = a_q;
      b_d     = b_q;
      sq_d    = sq_q;
      sr_d    = sr_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            // done_q high means we are in the done cycle; starts are ignored there.
            if (start && !done_q) begin
               if (divisor == '0) begin
                  quot_d  = '1;
                  rem_d   = dividend;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end else begin
                  a_d     = (signed_op && dividend[WIDTH-1]) ? -dividend : dividend;
                  b_d     = (signed_op && divisor[WIDTH-1])  ? -divisor  : divisor;
                  sq_d    = signed_op && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  sr_d    = signed_op && dividend[WIDTH-1];
                  count_d = '0;
                  p_d     = '0;
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            p_d     = carry ? trial[WIDTH:0] : p_shift;
            a_d     = {a_q[WIDTH-2:0], carry};
            count_d = count_q + CW'(1);
            if (count_q == CW'(WIDTH-1)) begin
               state_d = FIX;
            end
         end
         FIX: begin
            quot_d  = sq_q ? -a_q : a_q;
            rem_d   = sr_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
            dbz_d   = 1'b0;
            state_d = DONE;
         end
         default: begin
            // DONE: the pulse itself is registered, so it appears next cycle.
            done_d  = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         state_q <= IDLE;
         count_q <= '0;
         p_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sq_q    <= 1'b0;
         sr_q    <= 1'b0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         p_q     <= p_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sq_q    <= sq_d;
         sr_q    <= sr_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
         done_q  <= done_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign done        = done_q;
   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq - directed test of div_seq (WIDTH=32) with hand-computed results.
module tb_div_seq;

   logic        clock = 1'b0;
   logic        clear, start, signed_op;
   logic [31:0] dividend, divisor;
   logic        busy, done, div_by_zero;
   logic [31:0] quotient, remainder;

   int checks = 0;
   int errors = 0;

   div_seq #(.WIDTH(32)) dut (
      .clock       (clock),
      .clear       (clear),
      .start       (start),
      .signed_op   (signed_op),
      .dividend    (dividend),
      .divisor     (divisor),
      .busy        (busy),
      .done        (done),
      .quotient    (quotient),
      .remainder   (remainder),
      .div_by_zero (div_by_zero)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Issue one divide and wait (bounded) for done. lat = number of rising
   // edges after the accepting edge until done is seen.
   task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
      @(negedge clock);
      start = 1'b1; signed_op = sgn; dividend = a; divisor = b;
      @(posedge clock); #1;
      start = 1'b0;
      dividend = 32'hDEAD_BEEF; divisor = 32'h0000_0003;
      lat = 0;
      while (!done && lat < 100) begin
         @(posedge clock); #1;
         lat++;
      end
   endtask

   typedef struct {
      string       name;
      logic        sgn;
      logic [31:0] a, b, q, r;
      logic        dbz;
      int          lat;
   } vec_t;

   vec_t vecs[$];
   int   lat;
   int   ndone;

   initial begin
      clear = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clock);
      #1;
      check("rst_busy", {31'b0, busy}, 32'd0);
      check("rst_done", {31'b0, done}, 32'd0);
      check("rst_quot", quotient, 32'd0);
      check("rst_rem",  remainder, 32'd0);
      check("rst_dbz",  {31'b0, div_by_zero}, 32'd0);
      @(negedge clock); clear = 1'b0;

      vecs.push_back('{"u100_7",   1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 34});
      vecs.push_back('{"s-100_7",  1'b1, 32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, 34});
      vecs.push_back('{"s100_-7",  1'b1, 32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0, 34});
      vecs.push_back('{"s-100_-7", 1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0, 34});
      vecs.push_back('{"u5_0",     1'b0, 32'd5,         32'd0,         32'hFFFFFFFF,  32'd5,         1'b1, 1});
      vecs.push_back('{"u9_3",     1'b0, 32'd9,         32'd3,         32'd3,         32'd0,         1'b0, 34});
      vecs.push_back('{"s_min_-1", 1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         1'b0, 34});
      vecs.push_back('{"u_max_1",  1'b0, 32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0,         1'b0, 34});
      vecs.push_back('{"u_min_max",1'b0, 32'h80000000,  32'hFFFFFFFF,  32'd0,         32'h80000000,  1'b0, 34});
      vecs.push_back('{"s-7_2",    1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 34});
      vecs.push_back('{"s-9_0",    1'b1, 32'hFFFFFFF7,  32'd0,         32'hFFFFFFFF,  32'hFFFFFFF7,  1'b1, 1});

      foreach (vecs[i]) begin
         do_div(vecs[i].sgn, vecs[i].a, vecs[i].b, lat);
         check({vecs[i].name, "_lat"},  lat, vecs[i].lat);
         check({vecs[i].name, "_quot"}, quotient, vecs[i].q);
         check({vecs[i].name, "_rem"},  remainder, vecs[i].r);
         check({vecs[i].name, "_dbz"},  {31'b0, div_by_zero}, {31'b0, vecs[i].dbz});
         check({vecs[i].name, "_busy"}, {31'b0, busy}, 32'd0);
         @(posedge clock); #1;
         check({vecs[i].name, "_pulse"}, {31'b0, done}, 32'd0);
         check({vecs[i].name, "_hold"},  quotient, vecs[i].q);
      end

      // Starts while busy / in the done cycle must be ignored.
      @(negedge clock);
      start = 1'b1; signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7;
      @(posedge clock); #1;
      start = 1'b0;
      check("busy_after_accept", {31'b0, busy}, 32'd1);
      ndone = 0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clock);
         if (k == 5 || k == 34 || k == 35) begin
            start = 1'b1; dividend = 32'd50; divisor = 32'd5;
         end else begin
            start = 1'b0;
         end
         @(posedge clock); #1;
         if (done) begin
            ndone++;
            check("ign_lat",  k, 34);
            check("ign_quot", quotient, 32'd14);
            check("ign_rem",  remainder, 32'd2);
         end
      end
      start = 1'b0;
      check("ign_ndone", ndone, 1);
      check("ign_idle",  {31'b0, busy}, 32'd0);

      // Clear mid-operation, with a simultaneous start that must be dropped.
      @(negedge clock);
      start = 1'b1; dividend = 32'd100; divisor = 32'd7;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (9) @(posedge clock);
      @(negedge clock);
      clear = 1'b1; start = 1'b1; dividend = 32'd50; divisor = 32'd5;
      @(posedge clock); #1;
      clear = 1'b0; start = 1'b0;
      check("clr_busy", {31'b0, busy}, 32'd0);
      check("clr_done", {31'b0, done}, 32'd0);
      check("clr_quot", quotient, 32'd0);
      check("clr_rem",  remainder, 32'd0);
      check("clr_dbz",  {31'b0, div_by_zero}, 32'd0);
      ndone = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clock); #1;
         if (done || busy) ndone++;
      end
      check("clr_quiet", ndone, 0);

      do_div(1'b0, 32'd50, 32'd5, lat);
      check("u50_5_lat",  lat, 34);
      check("u50_5_quot", quotient, 32'd10);
      check("u50_5_rem",  remainder, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
